// File: rtl/data_buffer_core.sv
// data_buffer_core: linear single-packet byte buffer.
// Bytes land at the externally supplied store_ptr. The buffer owns the
// get pointer and the occupancy count. Reads are registered and show up
// one cycle after the strobe. Pointers never wrap; clr rewinds the
// buffer for the next packet.
module data_buffer_core #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int PTR_W  = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic [PTR_W-1:0]  store_ptr,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              store_rx_packet_data,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              get_rx_data,
    input  logic              get_tx_packet_data,
    output logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_packet_data,
    output logic [PTR_W-1:0]  get_ptr,
    output logic [PTR_W-1:0]  buffer_occupancy,
    output logic              read_err
);

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W-1:0] ZERO_P  = '0;

    // Storage is never reset; contents are only meaningful once written.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  get_ptr_q, get_ptr_d;
    logic [PTR_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_pkt_q, tx_pkt_d;
    logic              read_err_q, read_err_d;

    logic              store_req, store_acc;
    logic              get_req, get_acc, get_empty;
    logic [DATA_W-1:0] wr_byte;
    logic [DATA_W-1:0] rd_byte;
    logic [PTR_W-2:0]  wr_idx, rd_idx;

    // Request qualification. Host data wins when both writers strobe,
    // matching the store pointer controller which advances only once.
    // A store at store_ptr==DEPTH is dropped without any indication.
    always_comb begin
        store_req = store_tx_data | store_rx_packet_data;
        store_acc = store_req & ~clr & (store_ptr < DEPTH_P);
        wr_byte   = store_tx_data ? tx_data : rx_packet_data;
        wr_idx    = store_ptr[PTR_W-2:0];
        get_req   = get_rx_data | get_tx_packet_data;
        get_empty = (occ_q == ZERO_P);
        get_acc   = get_req & ~clr & ~get_empty;
        rd_idx    = get_ptr_q[PTR_W-2:0];
        rd_byte   = mem_q[rd_idx];
    end

    // Next-state for pointer, occupancy, read data and error pulse.
    always_comb begin
        get_ptr_d  = get_ptr_q;
        occ_d      = occ_q;
        rx_data_d  = rx_data_q;
        tx_pkt_d   = tx_pkt_q;
        read_err_d = 1'b0;
        if (clr) begin
            // Flush: strobes ignored, read data registers keep their value.
            get_ptr_d = ZERO_P;
            occ_d     = ZERO_P;
        end else begin
            read_err_d = get_req & get_empty;
            if (get_acc) begin
                // USB TX wins when both readers strobe; rx_data holds then.
                if (get_tx_packet_data) tx_pkt_d  = rd_byte;
                else                    rx_data_d = rd_byte;
                if (get_ptr_q != DEPTH_P) get_ptr_d = get_ptr_q + ONE_P;
            end
            unique case ({store_acc, get_acc})
                2'b10:   if (occ_q != DEPTH_P) occ_d = occ_q + ONE_P;
                2'b01:   occ_d = occ_q - ONE_P;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Memory write port; a same-cycle read sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (store_acc) mem_q[wr_idx] <= wr_byte;
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            get_ptr_q  <= '0;
            occ_q      <= '0;
            rx_data_q  <= '0;
            tx_pkt_q   <= '0;
            read_err_q <= 1'b0;
        end else begin
            get_ptr_q  <= get_ptr_d;
            occ_q      <= occ_d;
            rx_data_q  <= rx_data_d;
            tx_pkt_q   <= tx_pkt_d;
            read_err_q <= read_err_d;
        end
    end

    assign get_ptr          = get_ptr_q;
    assign buffer_occupancy = occ_q;
    assign rx_data          = rx_data_q;
    assign tx_packet_data   = tx_pkt_q;
    assign read_err         = read_err_q;

endmodule

// File: tb/tb_data_buffer_core.sv
// Bench for data_buffer_core. The bench plays the store pointer
// controller (store_ptr = bytes stored since last clr) and keeps a
// packet-level model: an array of bytes plus store/read counts.
module tb_data_buffer_core;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] store_ptr = '0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = '0;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = '0;
    logic       get_rx_data = 1'b0;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] rx_data;
    logic [7:0] tx_packet_data;
    logic [6:0] get_ptr;
    logic [6:0] buffer_occupancy;
    logic       read_err;

    int errors = 0;
    int checks = 0;

    // Model: packet bytes, bytes stored, bytes read, registered outputs.
    logic [7:0] m_mem [64];
    int         m_stored = 0;
    int         m_read = 0;
    logic [7:0] m_rx = '0;
    logic [7:0] m_tx = '0;
    logic       m_err = 1'b0;

    data_buffer_core dut (
        .clk(clk), .n_rst(n_rst), .clr(clr), .store_ptr(store_ptr),
        .store_tx_data(store_tx_data), .tx_data(tx_data),
        .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data),
        .get_rx_data(get_rx_data), .get_tx_packet_data(get_tx_packet_data),
        .rx_data(rx_data), .tx_packet_data(tx_packet_data), .get_ptr(get_ptr),
        .buffer_occupancy(buffer_occupancy), .read_err(read_err)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive, update model, clock, release strobes.
    task automatic op(input bit s_tx, input bit s_rx, input logic [7:0] d_tx,
                      input logic [7:0] d_rx, input bit g_rx, input bit g_tx, input bit c);
        int avail;
        store_ptr = 7'(m_stored);
        store_tx_data = s_tx; tx_data = d_tx;
        store_rx_packet_data = s_rx; rx_packet_data = d_rx;
        get_rx_data = g_rx; get_tx_packet_data = g_tx; clr = c;
        avail = m_stored - m_read;
        if (c) begin
            m_stored = 0; m_read = 0; m_err = 1'b0;
        end else begin
            m_err = (g_rx || g_tx) && avail == 0;
            if ((g_rx || g_tx) && avail > 0) begin
                if (g_tx) m_tx = m_mem[m_read];
                else      m_rx = m_mem[m_read];
                m_read++;
            end
            if ((s_tx || s_rx) && m_stored < 64) begin
                m_mem[m_stored] = s_tx ? d_tx : d_rx;
                m_stored++;
            end
        end
        @(posedge clk); #1;
        store_tx_data = 0; store_rx_packet_data = 0;
        get_rx_data = 0; get_tx_packet_data = 0; clr = 0;
        store_ptr = 7'(m_stored);
    endtask

    task automatic test_reset();
        n_rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (get_ptr !== 7'd0 || buffer_occupancy !== 7'd0 || rx_data !== 8'd0 ||
            tx_packet_data !== 8'd0 || read_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gp=%0d occ=%0d rx=%h tx=%h err=%b required all zero",
                     get_ptr, buffer_occupancy, rx_data, tx_packet_data, read_err);
        end
        n_rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_host_write_usb_read();
        op(0, 0, 0, 0, 0, 0, 1);
        op(1, 0, 8'hA5, 0, 0, 0, 0);
        op(1, 0, 8'h3C, 0, 0, 0, 0);
        checks++;
        if (buffer_occupancy !== 7'd2) begin
            errors++; $display("FAIL hw_occ: got %0d want 2", buffer_occupancy);
        end
        op(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (tx_packet_data !== 8'hA5) begin
            errors++; $display("FAIL hw_tx0: got %h want a5", tx_packet_data);
        end
        op(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (tx_packet_data !== 8'h3C || get_ptr !== 7'd2 || buffer_occupancy !== 7'd0) begin
            errors++;
            $display("FAIL hw_tx1: tx=%h gp=%0d occ=%0d want 3c 2 0",
                     tx_packet_data, get_ptr, buffer_occupancy);
        end
    endtask

    task automatic test_fill();
        int bad;
        op(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 64; i++) op(0, 1, 0, 8'(i), 0, 0, 0);
        checks++;
        if (buffer_occupancy !== 7'd64) begin
            errors++; $display("FAIL fill_occ: got %0d want 64", buffer_occupancy);
        end
        op(0, 1, 0, 8'hFF, 0, 0, 0);
        checks++;
        if (buffer_occupancy !== 7'd64) begin
            errors++; $display("FAIL overflow_drop: occ=%0d want 64", buffer_occupancy);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            op(0, 0, 0, 0, 1, 0, 0);
            checks++;
            if (rx_data !== 8'(i)) begin
                errors++;
                if (bad++ < 4) $display("FAIL fill_read[%0d]: got %h want %h", i, rx_data, 8'(i));
            end
        end
        checks++;
        if (get_ptr !== 7'd64 || buffer_occupancy !== 7'd0) begin
            errors++; $display("FAIL fill_end: gp=%0d occ=%0d want 64 0", get_ptr, buffer_occupancy);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] first;
        op(0, 0, 0, 0, 0, 0, 1);
        first = 8'($urandom);
        op(1, 0, first, 0, 0, 0, 0);
        op(0, 1, 0, 8'($urandom), 0, 0, 0);
        op(1, 0, 8'($urandom), 0, 0, 0, 0);
        op(1, 0, 8'($urandom), 0, 1, 0, 0);
        checks++;
        if (buffer_occupancy !== 7'd3 || get_ptr !== 7'd1 || rx_data !== first) begin
            errors++;
            $display("FAIL simul: occ=%0d gp=%0d rx=%h want 3 1 %h",
                     buffer_occupancy, get_ptr, rx_data, first);
        end
    endtask

    task automatic test_empty_read();
        logic [7:0] rx_before;
        logic [6:0] gp_before;
        // Drain so occupancy reaches zero without a clear.
        while (m_stored - m_read > 0) op(0, 0, 0, 0, 1, 0, 0);
        rx_before = rx_data; gp_before = get_ptr;
        op(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (read_err !== 1'b1 || get_ptr !== gp_before || rx_data !== rx_before) begin
            errors++;
            $display("FAIL empty_read: err=%b gp=%0d rx=%h want 1 %0d %h",
                     read_err, get_ptr, rx_data, gp_before, rx_before);
        end
        op(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (read_err !== 1'b0) begin
            errors++; $display("FAIL empty_read_pulse: err=%b want 0", read_err);
        end
    endtask

    task automatic test_clear();
        logic [7:0] tx_before;
        op(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) op(1, 0, 8'($urandom), 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1, 0);
        op(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (get_ptr !== 7'd2 || buffer_occupancy !== 7'd3 || tx_packet_data !== m_mem[1]) begin
            errors++;
            $display("FAIL clr_setup: gp=%0d occ=%0d tx=%h want 2 3 %h",
                     get_ptr, buffer_occupancy, tx_packet_data, m_mem[1]);
        end
        tx_before = tx_packet_data;
        op(1, 0, 8'h77, 0, 0, 1, 1);
        checks++;
        if (get_ptr !== 7'd0 || buffer_occupancy !== 7'd0 || tx_packet_data !== tx_before ||
            read_err !== 1'b0) begin
            errors++;
            $display("FAIL clr: gp=%0d occ=%0d tx=%h err=%b want 0 0 %h 0",
                     get_ptr, buffer_occupancy, tx_packet_data, read_err, tx_before);
        end
        // Refill, read one, then pulse reset between clock edges.
        for (int i = 0; i < 3; i++) op(0, 1, 0, 8'($urandom_range(1, 255)), 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        #3 n_rst = 0;
        #1;
        checks++;
        if (get_ptr !== 7'd0 || buffer_occupancy !== 7'd0 || rx_data !== 8'd0 ||
            tx_packet_data !== 8'd0 || read_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gp=%0d occ=%0d rx=%h tx=%h err=%b want all zero",
                     get_ptr, buffer_occupancy, rx_data, tx_packet_data, read_err);
        end
        #2 n_rst = 1;
        m_stored = 0; m_read = 0; m_rx = '0; m_tx = '0; m_err = 1'b0;
        store_ptr = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int bad = 0;
        op(0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            bit st, sr, gr, gt, c;
            st = ($urandom_range(0, 3) == 0);
            sr = ($urandom_range(0, 2) == 0);
            gr = ($urandom_range(0, 3) == 0);
            gt = ($urandom_range(0, 4) == 0);
            c  = ($urandom_range(0, 60) == 0);
            op(st, sr, 8'($urandom), 8'($urandom), gr, gt, c);
            checks++;
            if (get_ptr !== 7'(m_read) || buffer_occupancy !== 7'(m_stored - m_read) ||
                rx_data !== m_rx || tx_packet_data !== m_tx || read_err !== m_err) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL random[%0d]: gp=%0d occ=%0d rx=%h tx=%h err=%b want %0d %0d %h %h %b",
                             n, get_ptr, buffer_occupancy, rx_data, tx_packet_data, read_err,
                             m_read, m_stored - m_read, m_rx, m_tx, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_host_write_usb_read();
        test_fill();
        test_simultaneous();
        test_empty_read();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
